uart_rx_byte: RTL

- 8N1 UART receiver that deserializes the usb_rx line into bytes for on-chip consumers, e.g. an LED display or a command parser.
- Sits between the top-level usb_rx pin and user logic, replacing raw pin echo with byte-level access.
- Output is a single-entry holding register with a valid/ready handshake.
- Reports framing errors and overruns as one-cycle pulses.

---
 rtl/uart_rx_byte.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_byte
// Brief    : 8N1 UART receiver with a single-entry valid/ready holding
//            register and one-cycle frame_err / overrun pulses.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int c_cnt_w = $clog2(CLKS_PER_BIT);

    // START leaves on the edge where the counter reaches CLKS_PER_BIT/2,
    // i.e. while it still holds CLKS_PER_BIT/2 - 1.
    localparam logic [c_cnt_w-1:0] c_start_pt = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    // DATA and STOP sample on the edge where the counter wraps.
    localparam logic [c_cnt_w-1:0] c_bit_end  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_baud_cnt;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 w_rx_s;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // Frame FSM, baud/bit counters and the registered output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // Consumer handshake; a completing byte below may re-set valid.
            if (valid && ready) begin
                valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_baud_cnt <= '0;
                    if (!w_rx_s) begin
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    if (r_baud_cnt == c_start_pt) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        // A line back high at mid start bit was only a glitch.
                        r_state    <= w_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_cnt_one;
                    end
                end

                S_DATA: begin
                    if (r_baud_cnt == c_bit_end) begin
                        r_baud_cnt         <= '0;
                        r_shift[r_bit_idx] <= w_rx_s;
                        r_bit_idx          <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_cnt_one;
                    end
                end

                S_STOP: begin
                    if (r_baud_cnt == c_bit_end) begin
                        r_baud_cnt <= '0;
                        if (w_rx_s) begin
                            r_state <= S_IDLE;
                            // Free or simultaneously drained holding register
                            // takes the byte; otherwise the new byte is lost.
                            if (!valid || ready) begin
                                data  <= r_shift;
                                valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            r_state   <= S_BREAK;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_cnt_one;
                    end
                end

                S_BREAK: begin
                    // Wait out a held-low line so it cannot spawn frames.
                    r_baud_cnt <= '0;
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_baud_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
